filter_rx: RTL and testbench

FILTER_RX -- requirements
Module: filter_rx

---
 rtl/filter_rx_pkg.sv | 20 ++
 rtl/filter_rx_fifo.sv | 68 ++++++
 rtl/filter_rx.sv | 114 +++++++++++
 tb/tb_filter_rx.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/filter_rx_pkg.sv
// Shared definitions for the filter receive path.
// Holds the default data width, buffer depth and error counter width used by
// both the upstream filter and filter_rx, plus the even-parity helper that
// both sides must compute identically.
package filter_rx_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefDepth = 4;
  localparam int unsigned DefCntW  = 8;

  // Widest word the parity helper accepts; narrower words are zero-extended,
  // which leaves the XOR-reduction unchanged.
  localparam int unsigned MaxWidth = 64;

  // Even parity: the parity bit equals the XOR of all data bits.
  function automatic logic calc_parity(input logic [MaxWidth-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/filter_rx_fifo.sv
// Receive buffer for filter_rx: a DEPTH-entry circular FIFO.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   i_push    - write i_data this edge (ignored when full unless popping too)
//   i_pop     - advance the head this edge (ignored when empty)
//   i_data    - word to write
//   o_data    - head-of-buffer word (reads 0 after reset until first push)
//   o_count   - occupancy, 0..DEPTH
//   o_full    - occupancy == DEPTH
//   o_empty   - occupancy == 0
module filter_rx_fifo
  import filter_rx_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned CountW = $clog2(DefDepth + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [WIDTH-1:0]  i_data,
  output logic [WIDTH-1:0]  o_data,
  output logic [CountW-1:0] o_count,
  output logic              o_full,
  output logic              o_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [CountW-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full  = (r_count == CountW'(DEPTH));
  assign o_empty = (r_count == '0);

  // A push into a full buffer is only legal when the head leaves the same edge.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem    <= '{default: '0};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PtrW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      r_count <= r_count + CountW'(w_do_push) - CountW'(w_do_pop);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/filter_rx.sv
// Receiver for words from the upstream filter.
// Checks even parity on each valid word, buffers good words in arrival order
// and tracks dropped words.
// Ports:
//   clk, rst    - clock, asynchronous active-low reset
//   y_data      - word from upstream (no backpressure)
//   y_valid     - y_data/y_parity valid this cycle
//   y_parity    - even parity bit for y_data
//   out_data    - head-of-buffer word
//   out_valid   - buffer non-empty
//   out_ready   - consumer accepts out_data when out_valid
//   err_clr     - clears err_count, parity_err, overflow
//   err_count   - saturating count of parity drops
//   parity_err  - sticky: any parity drop since clear
//   overflow    - sticky: any full-buffer drop since clear
//   full        - buffer holds DEPTH words
module filter_rx
  import filter_rx_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] y_data,
  input  logic             y_valid,
  input  logic             y_parity,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_count,
  output logic             parity_err,
  output logic             overflow,
  output logic             full
);

  localparam int unsigned      CountW = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [MaxWidth-1:0] w_data_ext;
  logic                w_parity_ok;
  logic                w_good;
  logic                w_bad;
  logic                w_pop;
  logic                w_drop;
  logic                w_full;
  logic                w_empty;
  logic [CountW-1:0]   w_count;

  logic [CNT_W-1:0] r_err_count;
  logic             r_parity_err;
  logic             r_overflow;

  assign w_data_ext  = MaxWidth'(y_data);
  assign w_parity_ok = (y_parity == calc_parity(w_data_ext));
  assign w_good      = y_valid & w_parity_ok;
  assign w_bad       = y_valid & ~w_parity_ok;
  assign w_pop       = out_ready & ~w_empty;
  // Full and nothing leaving: the good word has nowhere to go.
  assign w_drop      = w_good & w_full & ~w_pop;

  filter_rx_fifo #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .CountW (CountW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_good),
    .i_pop   (w_pop),
    .i_data  (y_data),
    .o_data  (out_data),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_valid = (w_count != '0);
  assign full      = w_full;

  // A same-edge error event takes priority over err_clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_count  <= '0;
      r_parity_err <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_bad) begin
        if (err_clr) begin
          r_err_count <= CNT_W'(1);
        end else if (r_err_count != CntMax) begin
          r_err_count <= r_err_count + CNT_W'(1);
        end
        r_parity_err <= 1'b1;
      end else if (err_clr) begin
        r_err_count  <= '0;
        r_parity_err <= 1'b0;
      end

      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (err_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign err_count  = r_err_count;
  assign parity_err = r_parity_err;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_filter_rx.sv
module tb_filter_rx;

  localparam int unsigned Width = 16;
  localparam int unsigned Depth = 4;
  localparam int unsigned CntW  = 8;
  localparam int unsigned CntMax = (1 << CntW) - 1;

  logic             clk;
  logic             rst;
  logic [Width-1:0] y_data;
  logic             y_valid;
  logic             y_parity;
  logic [Width-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             err_clr;
  logic [CntW-1:0]  err_count;
  logic             parity_err;
  logic             overflow;
  logic             full;

  filter_rx #(
    .WIDTH (Width),
    .DEPTH (Depth),
    .CNT_W (CntW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .y_data     (y_data),
    .y_valid    (y_valid),
    .y_parity   (y_parity),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err_clr    (err_clr),
    .err_count  (err_count),
    .parity_err (parity_err),
    .overflow   (overflow),
    .full       (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: expected words in arrival order plus error state.
  logic [Width-1:0] exp_q[$];
  int               m_occ  = 0;
  int               m_err  = 0;
  bit               m_perr = 1'b0;
  bit               m_ovf  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: a word is consumed at the next edge whenever out_valid && out_ready.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_out: got %0h expected no word at %0t", out_data, $time);
      end else begin
        chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Drive one cycle of inputs, advance the model, then check status after the edge.
  task automatic step(input logic v, input logic [Width-1:0] d, input logic p,
                      input logic r, input logic c);
    bit pop, good, bad, push;
    y_valid = v; y_data = d; y_parity = p; out_ready = r; err_clr = c;
    pop  = (m_occ > 0) && r;
    good = v && (p == ^d);
    bad  = v && (p != ^d);
    push = good && ((m_occ < Depth) || pop);
    m_occ = m_occ - int'(pop) + int'(push);
    if (push) exp_q.push_back(d);
    if (c) begin
      m_err = 0; m_perr = 1'b0; m_ovf = 1'b0;
    end
    if (bad) begin
      m_err  = (m_err >= CntMax) ? CntMax : m_err + 1;
      m_perr = 1'b1;
    end
    if (good && !push) m_ovf = 1'b1;
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_occ > 0));
    chk("full", 32'(full), 32'(m_occ == Depth));
    chk("err_count", 32'(err_count), 32'(m_err));
    chk("parity_err", 32'(parity_err), 32'(m_perr));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_occ = 0; m_err = 0; m_perr = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < Depth + 2 && m_occ > 0; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [Width-1:0] d;
    rst = 1'b0; y_valid = 1'b0; y_data = '0; y_parity = 1'b0;
    out_ready = 1'b0; err_clr = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;

    // Single good word emerges next cycle.
    step(1'b1, 16'h000C, 1'b0, 1'b0, 1'b0);
    chk("first_word", 32'(out_data), 32'h000C);
    drain();

    // Bad parity: no push, error counted; then clear.
    step(1'b1, 16'h000C, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Overflow on fifth word, then in-order drain.
    for (int i = 1; i <= 5; i++) step(1'b1, 16'(i), ^16'(i), 1'b0, 1'b0);
    drain();
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Full with simultaneous pop and push: no overflow, 9 last.
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), ^16'(i), 1'b0, 1'b0);
    step(1'b1, 16'h0009, ^16'h0009, 1'b1, 1'b0);
    chk("advance_head", 32'(out_data), 32'h0002);
    drain();

    // Reset mid-cycle discards buffered words.
    step(1'b1, 16'h00A5, ^16'h00A5, 1'b0, 1'b0);
    step(1'b1, 16'h005A, ^16'h005A, 1'b0, 1'b0);
    y_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_data", 32'(out_data), 32'd0);
    model_reset();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'h1234, ^16'h1234, 1'b1, 1'b0);
    drain();

    // Saturation of the error counter.
    for (int i = 0; i < CntMax + 4; i++) begin
      d = 16'($urandom);
      step(1'b1, d, ~(^d), 1'b0, 1'b0);
    end
    chk("sat_err_count", 32'(err_count), 32'(CntMax));
    // Clear in the same cycle as an error: error wins with count 1.
    step(1'b1, 16'h0003, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      d = 16'($urandom);
      step(1'($urandom_range(0, 3) != 0), d,
           ($urandom_range(0, 9) == 0) ? ~(^d) : ^d,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 29) == 0));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish by %0t", $time);
    $fatal(1);
  end

endmodule
